// File: rtl/stdcore_bbfifo_rd.sv
// stdcore_bbfifo_rd: block-FIFO consumer controller feeding a valid/ready stream via a 2-entry skid buffer.
// Define STDCORE_BBFIFO_RD_LAST_EN to add the o_last port and per-entry last flags.
module stdcore_bbfifo_rd #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int BLK   = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [DW-1:0] c,
    output logic [AW-1:0] c_raddr,
    output logic [AW-1:0] c_raddr_,
    output logic          c_re_n,
    output logic [AW:0]   c_pblk,
    input  logic [AW:0]   c_st,
    output logic [DW-1:0] o_data,
    output logic          o_vld,
    input  logic          o_rdy
`ifdef STDCORE_BBFIFO_RD_LAST_EN
    ,
    output logic          o_last
`endif
);

    localparam logic [AW-1:0] LAST_IDX = AW'(BLK - 1);
    localparam logic [AW:0]   BLK_W    = (AW + 1)'(BLK);
`ifdef STDCORE_BBFIFO_RD_LAST_EN
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    typedef enum logic {
        ST_WAIT,
        ST_READ
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] idx;
    logic          infl;
    logic [1:0]    occ;
    logic [EW-1:0] sk [2];
    logic [EW-1:0] sk_in;
    logic [2:0]    fill;
    logic          pop, space, issue, at_last;

    assign pop     = o_vld & o_rdy;
    assign fill    = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    assign space   = (fill < 3'd2);
    assign at_last = (idx == LAST_IDX);

    // The first read of a block is issued from WAIT in the same cycle the
    // start condition holds, so WAIT only drives c_re_n=1 while idle.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            ST_WAIT: begin
                if (space && (c_st >= BLK_W)) begin
                    issue    = 1'b1;
                    state_nx = at_last ? ST_WAIT : ST_READ;
                end
            end
            ST_READ: begin
                if (space) begin
                    issue = 1'b1;
                    if (at_last) state_nx = ST_WAIT;
                end
            end
            default: state_nx = ST_WAIT;
        endcase
    end

    assign c_re_n  = ~issue;
    assign c_raddr = idx;
    assign c_pblk  = (issue && at_last) ? BLK_W : '0;

    always_comb begin
        c_raddr_ = idx;
        if (issue) c_raddr_ = at_last ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= ST_WAIT;
            idx   <= '0;
            infl  <= 1'b0;
        end else begin
            state <= state_nx;
            infl  <= issue;
            if (issue) idx <= at_last ? '0 : idx + 1'b1;
        end
    end

`ifdef STDCORE_BBFIFO_RD_LAST_EN
    logic infl_last;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) infl_last <= 1'b0;
        else      infl_last <= issue & at_last;
    end

    assign sk_in  = {infl_last, c};
    assign o_last = o_vld & sk[0][DW];
`else
    assign sk_in  = c;
`endif

    // Entry 0 is always the head; a push lands behind whatever is still held.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            occ   <= '0;
            sk[0] <= '0;
            sk[1] <= '0;
        end else begin
            case ({infl, pop})
                2'b10: begin
                    if (occ == 2'd0) sk[0] <= sk_in;
                    else             sk[1] <= sk_in;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    sk[0] <= sk[1];
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        sk[0] <= sk_in;
                    end else begin
                        sk[0] <= sk[1];
                        sk[1] <= sk_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_vld  = (occ != 2'd0);
    assign o_data = sk[0][DW-1:0];

endmodule

// File: tb/tb_stdcore_bbfifo_rd.sv
// Bench for stdcore_bbfifo_rd: block-FIFO model plus scoreboard of the expected in-order word stream.
// Instance 0 uses BLK=4, instance 1 uses BLK=1; o_last checks follow STDCORE_BBFIFO_RD_LAST_EN.
module tb_stdcore_bbfifo_rd;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       push  [2];
    logic [7:0] pdata [2];
    logic       rdy   [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, g, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int B = (g == 0) ? 4 : 1;

        logic [7:0] c;
        logic [3:0] c_st;
        logic [2:0] c_raddr, c_raddr_;
        logic       c_re_n;
        logic [3:0] c_pblk;
        logic [7:0] o_data;
        logic       o_vld;
        logic       o_last;

        logic [7:0] mem [DEPTH];
        int         wptr, rbase;
        logic [8:0] exp_q [$];
        logic [8:0] e;
        int         nread, nxfer;
        logic [2:0] prev_nx;
        logic       prev_stall;
        logic [7:0] prev_data;

        stdcore_bbfifo_rd #(.DW(8), .DEPTH(DEPTH), .BLK(B)) dut (
            .clk      (clk),
            .arst     (rst),
            .c        (c),
            .c_raddr  (c_raddr),
            .c_raddr_ (c_raddr_),
            .c_re_n   (c_re_n),
            .c_pblk   (c_pblk),
            .c_st     (c_st),
            .o_data   (o_data),
            .o_vld    (o_vld),
`ifdef STDCORE_BBFIFO_RD_LAST_EN
            .o_last   (o_last),
`endif
            .o_rdy    (rdy[g])
        );

`ifndef STDCORE_BBFIFO_RD_LAST_EN
        assign o_last = 1'b0;
`endif

        assign c_st = 4'(wptr - rbase);

        // FIFO model: reads use the pre-release base; expected words queued on write.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr  <= 0;
                rbase <= 0;
                c     <= '0;
                exp_q.delete();
            end else begin
                if (!c_re_n) c <= mem[(rbase + int'(c_raddr)) % DEPTH];
                rbase <= rbase + int'(c_pblk);
                if (push[g] && (wptr - rbase) < DEPTH) begin
                    mem[wptr % DEPTH] <= pdata[g];
                    exp_q.push_back({((wptr % B) == B - 1), pdata[g]});
                    wptr <= wptr + 1;
                end
            end
        end

        always @(negedge clk or posedge rst) begin
            if (rst) begin
                nread      <= 0;
                nxfer      <= 0;
                prev_nx    <= '0;
                prev_stall <= 1'b0;
                prev_data  <= '0;
            end else begin
                check("outstanding", g, 32'((nread - nxfer) <= 2), 1);
                check("raddr_cont", g, c_raddr, prev_nx);
                if (!c_re_n) begin
                    check("raddr", g, c_raddr, nread % B);
                    check("pblk", g, c_pblk, ((nread % B) == B - 1) ? B : 0);
                    check("raddr_nx", g, c_raddr_, (nread + 1) % B);
                    nread <= nread + 1;
                end else begin
                    check("pblk_idle", g, c_pblk, 0);
                    check("raddr_hold", g, c_raddr_, c_raddr);
                end
                prev_nx <= c_raddr_;
                if (o_vld && rdy[g]) begin
                    check("sb_nonempty", g, 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("data", g, o_data, e[7:0]);
`ifdef STDCORE_BBFIFO_RD_LAST_EN
                        check("last", g, o_last, e[8]);
`endif
                    end
                    nxfer <= nxfer + 1;
                end
`ifdef STDCORE_BBFIFO_RD_LAST_EN
                if (!o_vld) check("last_idle", g, o_last, 0);
`endif
                if (prev_stall) begin
                    check("hold_vld", g, o_vld, 1);
                    check("hold_data", g, o_data, prev_data);
                end
                prev_stall <= o_vld && !rdy[g];
                prev_data  <= o_data;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int g, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push[g]  = 1'b1;
            pdata[g] = base + 8'(i);
            cyc(1);
        end
        push[g] = 1'b0;
    endtask

    // Counts instance-0 transfers and requires them on back-to-back cycles.
    task automatic watch(input string name, input int n_exp, input int budget);
        int cnt   = 0;
        int first = -1;
        int last  = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (gen[0].o_vld && rdy[0]) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        check({name, "_cnt"}, 0, cnt, n_exp);
        check({name, "_span"}, 0, last - first + 1, n_exp);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_raddr"}, 0, gen[0].c_raddr, 0);
        check({name, "_raddr_"}, 0, gen[0].c_raddr_, 0);
        check({name, "_re_n"}, 0, gen[0].c_re_n, 1);
        check({name, "_pblk"}, 0, gen[0].c_pblk, 0);
        check({name, "_vld"}, 0, gen[0].o_vld, 0);
        check({name, "_data"}, 0, gen[0].o_data, 0);
        check({name, "_last"}, 0, gen[0].o_last, 0);
    endtask

    initial begin
        int flag;
        int n;
        int reads;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int g = 0; g < 2; g++) begin
            push[g]  = 1'b0;
            pdata[g] = '0;
            rdy[g]   = 1'b1;
        end
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // One block, free-flowing output.
        fork
            push_seq(0, 8'h10, 4);
            watch("blk1", 4, 20);
        join

        // Two back-to-back blocks with no gap.
        fork
            push_seq(0, 8'h20, 8);
            watch("blk2", 8, 30);
        join

        // Backpressure with ready pattern 1,0,0,1.
        fork
            push_seq(0, 8'h60, 4);
            for (int k = 0; k < 24; k++) begin
                rdy[0] = pat[k % 4];
                cyc(1);
            end
        join
        rdy[0] = 1'b1;
        cyc(5);
        check("bp_drain", 0, gen[0].exp_q.size(), 0);

        // Stock one short of a block, then complete it.
        push_seq(0, 8'h70, 3);
        flag = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!gen[0].c_re_n || gen[0].o_vld) flag = 1;
        end
        check("idle_st3", 0, flag, 0);
        cyc(1);
        push[0]  = 1'b1;
        pdata[0] = 8'h73;
        cyc(1);
        push[0] = 1'b0;
        @(negedge clk);
        check("first_read", 0, gen[0].c_re_n, 0);
        n = 0;
        while (!gen[0].o_vld && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", 0, n, 2);
        cyc(8);

        // Reset after two reads of a block.
        push_seq(0, 8'h30, 4);
        reads = 0;
        for (int k = 0; k < 20 && reads < 2; k++) begin
            @(negedge clk);
            if (!gen[0].c_re_n) reads++;
        end
        check("pre_reset_reads", 0, reads, 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        cyc(1);
        rst = 1'b0;
        fork
            push_seq(0, 8'h40, 4);
            watch("post_rst", 4, 20);
        join

        // BLK=1 instance.
        push_seq(1, 8'h50, 3);
        cyc(10);
        check("blk1_reads", 1, gen[1].nread, 3);
        check("blk1_drain", 1, gen[1].exp_q.size(), 0);

        // Randomized traffic on both instances.
        for (int k = 0; k < 1500; k++) begin
            for (int g = 0; g < 2; g++) begin
                push[g]  = 1'($urandom_range(0, 1));
                pdata[g] = 8'($urandom);
                rdy[g]   = ($urandom_range(0, 3) != 0);
            end
            cyc(1);
        end
        for (int g = 0; g < 2; g++) begin
            push[g] = 1'b0;
            rdy[g]  = 1'b1;
        end
        cyc(30);
        check("rand_drain0", 0, gen[0].exp_q.size(), gen[0].c_st);
        check("rand_drain1", 1, gen[1].exp_q.size(), gen[1].c_st);
        check("rand_xfer0", 0, gen[0].nxfer, gen[0].nread);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
